// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: bit-period computation, 8N1 frame
//               constants and the transmitter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int   c_DATA_BITS  = 8;
    localparam int   c_STOP_BITS  = 1;
    localparam logic c_IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Clock cycles per serial bit. Integer division, never below one so a
    // very slow clock still produces a usable (if inaccurate) bit period.
    function automatic int calc_clks_per_bit(input int sys_clk_freq, input int baud_rate);
        int q;
        q = sys_clk_freq / baud_rate;
        return (q < 1) ? 1 : q;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : uart_transmitter
// Description : 8N1 UART transmitter. Loads a byte when start=1 and the
//               transmitter can accept, then sends start bit, 8 data bits
//               LSB first and one stop bit, each CLKS_PER_BIT cycles long.
// Ports       : clk   - system clock
//               reset - synchronous active-high reset
//               start - a byte is available on data
//               data  - byte to send, taken when start=1 and busy=0
//               busy  - low when a byte offered on start/data is accepted
//                       this cycle (idle, or final cycle of the stop bit)
//               tx    - registered serial output, idle high
// Revision    : 1.0 - initial release
// ============================================================================
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);
    import uart_pkg::*;

    localparam int                  c_BAUD_W    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]          c_LAST_IDX  = 3'(c_DATA_BITS - 1);

    tx_state_t           r_state;
    tx_state_t           w_state_nxt;
    logic [c_BAUD_W-1:0] r_baud;
    logic [c_BAUD_W-1:0] w_baud_nxt;
    logic [2:0]          r_idx;
    logic [2:0]          w_idx_nxt;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_nxt;
    logic                r_tx;
    logic                w_tx_nxt;
    logic                w_bit_done;
    logic                w_accept;

    assign w_bit_done = (r_baud == c_BAUD_LAST);
    // Accepting in the last stop cycle lets frames run back to back.
    assign w_accept   = (r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_done);
    assign busy       = ~w_accept;
    assign tx         = r_tx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= c_IDLE_LEVEL;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_baud_nxt  = w_bit_done ? '0 : r_baud + 1'b1;
        w_tx_nxt    = c_IDLE_LEVEL;

        case (r_state)
            ST_IDLE: begin
                w_baud_nxt = '0;
                if (start) begin
                    w_state_nxt = ST_START;
                    w_shift_nxt = data;
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    w_state_nxt = ST_DATA;
                    w_idx_nxt   = '0;
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    if (start) begin
                        w_state_nxt = ST_START;
                        w_shift_nxt = data;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Output is registered from the next state, so the line level changes
        // exactly on the bit boundary with no combinational path to the pin.
        case (w_state_nxt)
            ST_START: w_tx_nxt = 1'b0;
            ST_DATA:  w_tx_nxt = w_shift_nxt[0];
            default:  w_tx_nxt = c_IDLE_LEVEL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/uart_dbg.sv
`default_nettype none
// ============================================================================
// Module      : uart_dbg
// Description : Debug byte sink. Bytes written with wr are queued in a FIFO
//               of MSG_QUEUE_SIZE entries and sent out on tx as 8N1 frames.
// Ports       : clk   - system clock
//               reset - synchronous active-high reset
//               wr    - write strobe, one byte per cycle
//               msg   - byte enqueued when wr=1 and full=0
//               tx    - UART serial output, idle high
//               full  - FIFO holds MSG_QUEUE_SIZE bytes; writes are dropped
// Revision    : 1.0 - initial release
// ============================================================================
module uart_dbg #(
    parameter int SYS_CLK_FREQ   = 12000000,
    parameter int BAUD_RATE      = 115200,
    parameter int MSG_QUEUE_SIZE = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr,
    input  logic [7:0] msg,
    output logic       tx,
    output logic       full
);
    import uart_pkg::*;

    localparam int                 c_CLKS_PER_BIT = calc_clks_per_bit(SYS_CLK_FREQ, BAUD_RATE);
    localparam int                 c_PTR_W        = $clog2(MSG_QUEUE_SIZE);
    localparam int                 c_CNT_W        = $clog2(MSG_QUEUE_SIZE + 1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT     = c_CNT_W'(MSG_QUEUE_SIZE);

    logic [7:0]         r_mem [MSG_QUEUE_SIZE];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_busy;

    assign full    = (r_count == c_FULL_CNT);
    assign w_empty = (r_count == '0);
    // Full is judged before any same-cycle pop, so a write into a full FIFO
    // is always dropped even while the transmitter drains an entry.
    assign w_push  = wr & ~full;
    assign w_pop   = ~w_empty & ~w_busy;

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= msg;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    uart_transmitter #(
        .CLKS_PER_BIT (c_CLKS_PER_BIT)
    ) u_transmitter (
        .clk   (clk),
        .reset (reset),
        .start (~w_empty),
        .data  (r_mem[r_rd_ptr]),
        .busy  (w_busy),
        .tx    (tx)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_dbg.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_dbg
// Description : Self-checking bench for uart_dbg. Two instances (one clock
//               per bit with depth 8, three clocks per bit with depth 4) see
//               the same stimulus; a frame-position reference model predicts
//               tx and full every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_dbg;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr = 1'b0;
    logic [7:0] msg = 8'h00;
    logic       tx0, full0, tx1, full1;
    logic       chk_en = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_dbg #(
        .SYS_CLK_FREQ   (1),
        .BAUD_RATE      (4),
        .MSG_QUEUE_SIZE (8)
    ) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .wr    (wr),
        .msg   (msg),
        .tx    (tx0),
        .full  (full0)
    );

    uart_dbg #(
        .SYS_CLK_FREQ   (12000000),
        .BAUD_RATE      (4000000),
        .MSG_QUEUE_SIZE (4)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .wr    (wr),
        .msg   (msg),
        .tx    (tx1),
        .full  (full1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Queue of accepted bytes plus the position (in cycles) inside the frame
    // currently on the line; -1 means the line is idle.
    logic [7:0] mbuf [2][64];
    int         mhead [2] = '{0, 0};
    int         mtail [2] = '{0, 0};
    int         mpos  [2] = '{-1, -1};
    logic [7:0] mcur  [2] = '{8'h00, 8'h00};

    function automatic int cpb_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int depth_of(input int k);
        return (k == 0) ? 8 : 4;
    endfunction

    task automatic model_step(input int k);
        int  sz;
        int  flen;
        sz   = mtail[k] - mhead[k];
        flen = 10 * cpb_of(k);
        if (reset) begin
            mhead[k] = 0;
            mtail[k] = 0;
            mpos[k]  = -1;
        end else begin
            if (((mpos[k] == -1) || (mpos[k] == flen - 1)) && (sz > 0)) begin
                mcur[k] = mbuf[k][mhead[k] % 64];
                mhead[k]++;
                mpos[k] = 0;
            end else if (mpos[k] == flen - 1) begin
                mpos[k] = -1;
            end else if (mpos[k] >= 0) begin
                mpos[k]++;
            end
            if (wr && (sz < depth_of(k))) begin
                mbuf[k][mtail[k] % 64] = msg;
                mtail[k]++;
            end
        end
    endtask

    function automatic logic exp_tx(input int k);
        int b;
        if (mpos[k] < 0) return 1'b1;
        b = mpos[k] / cpb_of(k);
        if (b == 0) return 1'b0;
        if (b <= 8) return mcur[k][b-1];
        return 1'b1;
    endfunction

    function automatic logic exp_full(input int k);
        return (mtail[k] - mhead[k]) == depth_of(k);
    endfunction

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_val("tx0",   {31'd0, tx0},   {31'd0, exp_tx(0)});
            check_val("full0", {31'd0, full0}, {31'd0, exp_full(0)});
            check_val("tx1",   {31'd0, tx1},   {31'd0, exp_tx(1)});
            check_val("full1", {31'd0, full1}, {31'd0, exp_full(1)});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int a5_seq [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    initial begin
        // Reset, then idle line with no writes.
        tick;
        chk_en = 1'b1;
        reset  = 1'b0;
        repeat (50) tick;

        // Single byte: directed bit-sequence check on the 1 clk/bit instance.
        wr  = 1'b1;
        msg = 8'hA5;
        tick;
        wr  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_val($sformatf("a5_bit%0d", i), {31'd0, tx0}, a5_seq[i]);
        end
        repeat (40) tick;

        // Burst of 0..7 on consecutive cycles.
        for (int v = 0; v < 8; v++) begin
            wr  = 1'b1;
            msg = v[7:0];
            tick;
        end
        wr = 1'b0;
        repeat (300) tick;

        // Continuous writes from reset release: overflow with concurrent pops.
        reset = 1'b1;
        tick;
        reset = 1'b0;
        for (int v = 0; v < 200; v++) begin
            wr  = 1'b1;
            msg = v[7:0];
            tick;
        end
        wr = 1'b0;
        repeat (350) tick;

        // Reset in the middle of a frame's data bits, then a fresh byte.
        wr  = 1'b1;
        msg = 8'hF0;
        tick;
        msg = 8'h81;
        tick;
        wr  = 1'b0;
        repeat (7) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        @(negedge clk);
        check_val("post_rst_tx1",   {31'd0, tx1},   32'd1);
        check_val("post_rst_full0", {31'd0, full0}, 32'd0);
        tick;
        wr  = 1'b1;
        msg = 8'h3C;
        tick;
        wr  = 1'b0;
        repeat (45) tick;

        // Randomized traffic at several write densities with rare resets.
        for (int blk = 0; blk < 3; blk++) begin
            int rate;
            rate = (blk == 0) ? 20 : (blk == 1) ? 60 : 95;
            repeat (600) begin
                wr    = ($urandom_range(0, 99) < rate);
                msg   = 8'($urandom);
                reset = ($urandom_range(0, 399) == 0);
                tick;
            end
        end
        wr    = 1'b0;
        reset = 1'b0;
        repeat (200) tick;

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
